// File: rtl/mac_kbd_pkg.sv
// Shared definitions for the Mac keyboard protocol engine: command codes, reply
// bytes, FSM states and the keypad byte-sequence helpers used with MAC_KBD_KEYPAD_EN.
package mac_kbd_pkg;

  localparam logic [7:0] CMD_INQUIRY   = 8'h10;
  localparam logic [7:0] CMD_INSTANT   = 8'h14;
  localparam logic [7:0] CMD_MODEL     = 8'h16;
  localparam logic [7:0] CMD_TEST      = 8'h36;
  localparam logic [7:0] NULL_REPLY    = 8'h7B;
  localparam logic [7:0] KEYPAD_PREFIX = 8'h79;
  localparam logic [6:0] SHIFT_PREFIX  = 7'h71;

  typedef enum logic [1:0] {ST_IDLE, ST_PACE, ST_INQ} state_e;
  typedef enum logic [1:0] {OP_INQUIRY, OP_INSTANT, OP_MODEL, OP_TEST} op_e;

  // Byte emitted for a queued key at a given phase: shift prefix, keypad prefix, code.
  function automatic logic [7:0] key_byte(input logic [1:0] ext, input logic [7:0] code,
                                          input logic [1:0] phase);
    if (ext[1] && phase == 2'd0) return {code[7], SHIFT_PREFIX};
    if (ext[0] && phase == {1'b0, ext[1]}) return KEYPAD_PREFIX;
    return code;
  endfunction

  function automatic logic key_last(input logic [1:0] ext, input logic [1:0] phase);
    return phase == ({1'b0, ext[1]} + {1'b0, ext[0]});
  endfunction

endpackage

// File: rtl/mac_keyboard_if.sv
// Keyboard-side and Mac-side signal bundle of the keyboard engine.
interface mac_keyboard_if #(
  parameter int FIFO_DEPTH = 8
);
  logic                          kbd_strobe;
  logic [7:0]                    kbd_data;
  logic [1:0]                    kbd_ext;
  logic [7:0]                    data_out;
  logic                          strobe_out;
  logic [7:0]                    data_in;
  logic                          strobe_in;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          overflow;

  modport master (
    output kbd_strobe, kbd_data, kbd_ext, data_out, strobe_out,
    input  data_in, strobe_in, fifo_level, overflow
  );

  modport slave (
    input  kbd_strobe, kbd_data, kbd_ext, data_out, strobe_out,
    output data_in, strobe_in, fifo_level, overflow
  );
endinterface

// File: rtl/mac_kbd_fifo.sv
// Key queue: power-of-two circular buffer with flush; a push is accepted when full
// if a pop or flush frees a slot in the same cycle.
module mac_kbd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && (!full || do_pop || flush);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mac_keyboard.sv
// Mac keyboard protocol engine: captures toggle-strobed keys into a queue and answers
// paced Mac commands. MAC_KBD_KEYPAD_EN enables keypad/shift prefix byte sequences.
module mac_keyboard #(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         SHORT_TICKS = 4095,
  parameter int         LONG_TICKS  = 1048575,
  parameter logic [7:0] MODEL_ID    = 8'h0B,
  parameter logic [7:0] TEST_ACK    = 8'h7D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  mac_keyboard_if.slave     bus
);
  import mac_kbd_pkg::*;

  localparam int PW = $clog2(LONG_TICKS + 1);
  localparam logic [PW-1:0] SHORT_P = PW'(SHORT_TICKS);
  localparam logic [PW-1:0] LONG_P  = PW'(LONG_TICKS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef MAC_KBD_KEYPAD_EN
  localparam int ENTRY_W = 10;
`else
  localparam int ENTRY_W = 8;
`endif

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [PW-1:0]       pacer_q, pacer_d;
  logic                ks_q, ks_d, primed_q, primed_d;
  logic                overflow_q, overflow_d;
  logic                strobe_in_q, strobe_in_d;
  logic [7:0]          data_in_q, data_in_d;
  logic                push, pop, flush, take_key, full, empty;
  logic [ENTRY_W-1:0]  entry_in, head;
  logic [LW-1:0]       level;
  logic [7:0]          next_byte;
  logic                next_last;

`ifdef MAC_KBD_KEYPAD_EN
  logic [1:0] phase_q, phase_d;

  assign entry_in  = {bus.kbd_ext, bus.kbd_data};
  assign next_byte = key_byte(head[9:8], head[7:0], phase_q);
  assign next_last = key_last(head[9:8], phase_q);

  always_comb begin
    phase_d = phase_q;
    if (take_key) phase_d = next_last ? 2'd0 : phase_q + 2'd1;
    if (flush)    phase_d = 2'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= 2'd0;
    else          phase_q <= phase_d;
  end
`else
  logic unused_ext;
  assign unused_ext = ^bus.kbd_ext;
  assign entry_in   = bus.kbd_data;
  assign next_byte  = head;
  assign next_last  = 1'b1;
`endif

  assign pop = take_key && next_last;

  mac_kbd_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (entry_in),
    .head    (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pacer_d     = pacer_q;
    ks_d        = ks_q;
    primed_d    = primed_q;
    overflow_d  = overflow_q;
    strobe_in_d = strobe_in_q;
    data_in_d   = data_in_q;
    push        = 1'b0;
    flush       = 1'b0;
    take_key    = 1'b0;
    if (en) begin
      strobe_in_d = 1'b0;
      ks_d        = bus.kbd_strobe;
      primed_d    = 1'b1;
      push        = primed_q && (bus.kbd_strobe != ks_q);
      if (pacer_q != LONG_P) pacer_d = pacer_q + 1'b1;

      // Reply decisions; the reply registers even if a new command arrives this cycle.
      case (state_q)
        ST_PACE: begin
          if (pacer_q == SHORT_P) begin
            state_d     = ST_IDLE;
            strobe_in_d = 1'b1;
            case (op_q)
              OP_MODEL:   data_in_d = MODEL_ID;
              OP_TEST:    data_in_d = TEST_ACK;
              OP_INSTANT: begin
                if (empty) data_in_d = NULL_REPLY;
                else       take_key  = 1'b1;
              end
              default: begin
                state_d     = ST_INQ;
                strobe_in_d = 1'b0;
              end
            endcase
          end
        end
        ST_INQ: begin
          if (!empty) begin
            take_key    = 1'b1;
            strobe_in_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (pacer_q == LONG_P) begin
            data_in_d   = NULL_REPLY;
            strobe_in_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: ;
      endcase
      if (take_key) data_in_d = next_byte;

      if (bus.strobe_out) begin
        pacer_d = '0;
        state_d = ST_PACE;
        case (bus.data_out)
          CMD_INQUIRY: op_d = OP_INQUIRY;
          CMD_INSTANT: op_d = OP_INSTANT;
          CMD_MODEL: begin
            op_d  = OP_MODEL;
            flush = 1'b1;
          end
          CMD_TEST: begin
            op_d       = OP_TEST;
            flush      = 1'b1;
            overflow_d = 1'b0;
          end
          default: state_d = ST_IDLE;
        endcase
      end

      if (push && full && !pop && !flush) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_INQUIRY;
      pacer_q     <= '0;
      ks_q        <= 1'b0;
      primed_q    <= 1'b0;
      overflow_q  <= 1'b0;
      strobe_in_q <= 1'b0;
      data_in_q   <= NULL_REPLY;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pacer_q     <= pacer_d;
      ks_q        <= ks_d;
      primed_q    <= primed_d;
      overflow_q  <= overflow_d;
      strobe_in_q <= strobe_in_d;
      data_in_q   <= data_in_d;
    end
  end

  assign bus.data_in    = data_in_q;
  assign bus.strobe_in  = strobe_in_q;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_mac_keyboard.sv
// Self-checking bench for mac_keyboard: command table, directed corner sequences and
// randomized key/command traffic against a queue-based reference model.
module tb_mac_keyboard;
  import mac_kbd_pkg::*;

  localparam int DEPTH = 4;
  localparam int S     = 12;
  localparam int L     = 40;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic en      = 1'b1;

  mac_keyboard_if #(.FIFO_DEPTH(DEPTH)) bus ();

  mac_keyboard #(
    .FIFO_DEPTH  (DEPTH),
    .SHORT_TICKS (S),
    .LONG_TICKS  (L),
    .MODEL_ID    (8'h0B),
    .TEST_ACK    (8'h7D)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [7:0] d; } rep_t;
  rep_t reps[$];
  logic si_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.strobe_in && !si_prev) reps.push_back('{cyc, bus.data_in});
    si_prev <= bus.strobe_in;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  // Reference model: queue of {ext,code} entries plus bytes already sent from the head.
  logic [9:0] m_q[$];
  int         m_ph  = 0;
  bit         m_ovf = 1'b0;

  function automatic int seq_len(logic [9:0] e);
    int n = 1;
`ifdef MAC_KBD_KEYPAD_EN
    n = n + int'(e[9]) + int'(e[8]);
`endif
    return n;
  endfunction

  function automatic logic [7:0] seq_at(logic [9:0] e, int idx);
    logic [7:0] s[$];
`ifdef MAC_KBD_KEYPAD_EN
    if (e[9]) s.push_back({e[7], 7'h71});
    if (e[8]) s.push_back(8'h79);
`endif
    s.push_back(e[7:0]);
    return s[idx];
  endfunction

  function automatic void model_push(logic [9:0] e);
    if (m_q.size() < DEPTH) m_q.push_back(e);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [7:0] model_reply();
    logic [7:0] b;
    if (m_q.size() == 0) return 8'h7B;
    b = seq_at(m_q[0], m_ph);
    m_ph++;
    if (m_ph == seq_len(m_q[0])) begin
      void'(m_q.pop_front());
      m_ph = 0;
    end
    return b;
  endfunction

  function automatic void model_flush();
    m_q.delete();
    m_ph = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick();
  endtask

  task automatic push_key(logic [7:0] d, logic [1:0] x);
    bus.kbd_data   = d;
    bus.kbd_ext    = x;
    bus.kbd_strobe = ~bus.kbd_strobe;
    tick();
    model_push({x, d});
  endtask

  task automatic send_cmd(logic [7:0] c, output int c0);
    bus.data_out   = c;
    bus.strobe_out = 1'b1;
    tick();
    bus.strobe_out = 1'b0;
    c0 = cyc;
    if (c == 8'h16 || c == 8'h36) model_flush();
    if (c == 8'h36) m_ovf = 1'b0;
  endtask

  task automatic expect_reply(string nm, int ec, logic [7:0] ed);
    rep_t r;
    wait_until(ec + 2);
    if (reps.size() == 0) begin
      n_tot++;
      $display("FAIL %s: no reply seen, required 0x%02h at cycle %0d", nm, ed, ec);
    end else begin
      r = reps.pop_front();
      chk({nm, "_cycle"}, r.c, ec);
      chk({nm, "_data"}, int'(r.d), int'(ed));
    end
  endtask

  task automatic expect_none(string nm);
    chk(nm, reps.size(), 0);
    reps.delete();
  endtask

  typedef struct { logic [7:0] cmd; bit rep; logic [7:0] data; int lat; } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl[6];
    int c0, c1, pc, act;
    logic [7:0] exp;
    rep_t r;

    tbl[0] = '{8'h16, 1'b1, 8'h0B, S + 1};
    tbl[1] = '{8'h36, 1'b1, 8'h7D, S + 1};
    tbl[2] = '{8'h14, 1'b1, 8'h7B, S + 1};
    tbl[3] = '{8'h10, 1'b1, 8'h7B, L + 1};
    tbl[4] = '{8'h55, 1'b0, 8'h00, 0};
    tbl[5] = '{8'h11, 1'b0, 8'h00, 0};

    bus.kbd_strobe = 1'b0;
    bus.kbd_data   = 8'h00;
    bus.kbd_ext    = 2'b00;
    bus.data_out   = 8'h00;
    bus.strobe_out = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_level", int'(bus.fifo_level), 0);
    chk("reset_overflow", int'(bus.overflow), 0);
    chk("reset_strobe_in", int'(bus.strobe_in), 0);
    chk("reset_data_in", int'(bus.data_in), 8'h7B);
    reset_n = 1'b1;
    tick();
    tick();

    // Command table
    for (int i = 0; i < 6; i++) begin
      send_cmd(tbl[i].cmd, c0);
      if (tbl[i].rep) begin
        expect_reply($sformatf("tbl%0d", i), c0 + tbl[i].lat, tbl[i].data);
      end else begin
        wait_until(c0 + L + 3);
        expect_none($sformatf("tbl%0d_noreply", i));
      end
      chk($sformatf("tbl%0d_level", i), int'(bus.fifo_level), 0);
    end

    // Inquiry answered by a key arriving while waiting
    send_cmd(8'h10, c0);
    wait_until(c0 + S + 10);
    push_key(8'h0D, 2'b00);
    pc  = cyc;
    exp = model_reply();
    wait_until(pc + 4);
    if (reps.size() == 0) begin
      n_tot++;
      $display("FAIL inq_key: no reply seen, required 0x%02h", exp);
    end else begin
      r = reps.pop_front();
      chk("inq_key_latency_ok", (r.c - pc <= 2 && r.c > pc) ? 1 : 0, 1);
      chk("inq_key_data", int'(r.d), int'(exp));
    end
    wait_until(c0 + L + 4);
    expect_none("inq_no_timeout_reply");
    chk("inq_level", int'(bus.fifo_level), m_q.size());

    // Keypad key with shift and keypad prefixes
    push_key(8'h8D, 2'b11);
    chk("kp_level0", int'(bus.fifo_level), m_q.size());
    for (int i = 0; i < 3; i++) begin
      send_cmd(8'h14, c0);
      expect_reply($sformatf("kp%0d", i), c0 + S + 1, model_reply());
      chk($sformatf("kp%0d_level", i), int'(bus.fifo_level), m_q.size());
    end

    // Overflow on a full queue, drained in order, cleared by TEST
    for (int i = 0; i < 5; i++) push_key(8'hB0 + 8'(i), 2'b00);
    chk("ovf_level", int'(bus.fifo_level), m_q.size());
    chk("ovf_flag", int'(bus.overflow), int'(m_ovf));
    for (int i = 0; i < 5; i++) begin
      send_cmd(8'h14, c0);
      expect_reply($sformatf("ovf_drain%0d", i), c0 + S + 1, model_reply());
    end
    send_cmd(8'h36, c0);
    expect_reply("ovf_test", c0 + S + 1, 8'h7D);
    chk("ovf_cleared", int'(bus.overflow), 0);

    // Push and final-byte pop on the same edge with a full queue
    for (int i = 0; i < 4; i++) push_key(8'hA0 + 8'(i), 2'b00);
    chk("full_level", int'(bus.fifo_level), m_q.size());
    send_cmd(8'h14, c0);
    wait_until(c0 + S);
    bus.kbd_data   = 8'hA4;
    bus.kbd_ext    = 2'b00;
    bus.kbd_strobe = ~bus.kbd_strobe;
    tick();
    exp = model_reply();
    model_push(10'h0A4);
    chk("simul_level", int'(bus.fifo_level), m_q.size());
    chk("simul_overflow", int'(bus.overflow), int'(m_ovf));
    expect_reply("simul", c0 + S + 1, exp);
    send_cmd(8'h16, c0);
    expect_reply("flush_model", c0 + S + 1, 8'h0B);
    chk("flush_level", int'(bus.fifo_level), 0);

    // Abort: a second command restarts pacing, only one reply results
    send_cmd(8'h10, c0);
    repeat (5) tick();
    send_cmd(8'h14, c1);
    expect_reply("abort", c1 + S + 1, model_reply());
    wait_until(c0 + L + 5);
    expect_none("abort_single");

    // Clock enable low freezes everything, including strobes
    send_cmd(8'h16, c0);
    repeat (3) tick();
    en = 1'b0;
    bus.kbd_strobe = ~bus.kbd_strobe;
    tick();
    bus.kbd_strobe = ~bus.kbd_strobe;
    tick();
    bus.data_out   = 8'h36;
    bus.strobe_out = 1'b1;
    tick();
    bus.strobe_out = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    expect_reply("en_hold", c0 + S + 1 + 7, 8'h0B);
    chk("en_level", int'(bus.fifo_level), 0);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      act = int'($urandom_range(0, 9));
      if (act <= 5) begin
        push_key(8'($urandom), 2'($urandom_range(0, 3)));
        chk("rnd_push_level", int'(bus.fifo_level), m_q.size());
        chk("rnd_push_ovf", int'(bus.overflow), int'(m_ovf));
      end else if (act <= 8) begin
        send_cmd(8'h14, c0);
        expect_reply("rnd_instant", c0 + S + 1, model_reply());
        chk("rnd_instant_level", int'(bus.fifo_level), m_q.size());
      end else begin
        send_cmd(8'h36, c0);
        expect_reply("rnd_test", c0 + S + 1, 8'h7D);
        chk("rnd_test_ovf", int'(bus.overflow), 0);
        chk("rnd_test_level", int'(bus.fifo_level), 0);
      end
    end

    // Reset during a pending inquiry with keys queued
    send_cmd(8'h16, c0);
    expect_reply("pre_rst_model", c0 + S + 1, 8'h0B);
    for (int i = 0; i < 3; i++) push_key(8'h20 + 8'(i), 2'b00);
    send_cmd(8'h10, c0);
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_level", int'(bus.fifo_level), 0);
    chk("rst_strobe_in", int'(bus.strobe_in), 0);
    chk("rst_data_in", int'(bus.data_in), 8'h7B);
    model_flush();
    m_ovf = 1'b0;
    bus.kbd_strobe = ~bus.kbd_strobe;
    tick();
    tick();
    reset_n = 1'b1;
    wait_until(c0 + L + 6);
    expect_none("rst_no_reply");
    chk("rst_first_sample_no_push", int'(bus.fifo_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
